// File: rtl/mac_chain_sequencer.sv
// Sequencer for a chain of MAC slices: loads per-tap coefficients, gates the
// shared calculate enable from sample/result handshakes, tracks result validity and flushes the tail.
module mac_chain_sequencer #(
  parameter int NUMBER_TAPS       = 8,
  parameter int DATA_WIDTH        = 16,
  parameter int COEFFICIENT_WIDTH = 16,
  parameter int CHAIN_LATENCY     = 3,
  parameter int FLUSH_LENGTH      = NUMBER_TAPS + CHAIN_LATENCY
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                load_start,
  input  logic                                coef_valid,
  output logic                                coef_ready,
  input  logic signed [COEFFICIENT_WIDTH-1:0] coef_data,
  input  logic                                coef_last,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DATA_WIDTH-1:0]        in_data,
  input  logic                                flush_start,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [DATA_WIDTH-1:0]        chain_data_in,
  output logic signed [COEFFICIENT_WIDTH-1:0] chain_coefficient,
  output logic [NUMBER_TAPS-1:0]              chain_ce_coefficient,
  output logic                                chain_reset_coefficient,
  output logic                                chain_ce_calculate,
  output logic                                busy,
  output logic                                load_error
);

  localparam int TAP_W   = $clog2(NUMBER_TAPS + 1);
  localparam int FLUSH_W = $clog2(FLUSH_LENGTH + 1);
  localparam logic [TAP_W-1:0]   LAST_TAP   = TAP_W'(NUMBER_TAPS - 1);
  localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(FLUSH_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

  state_t                   state;
  logic [TAP_W-1:0]         tap_idx;
  logic [FLUSH_W-1:0]       flush_cnt;
  logic                     loaded;
  logic                     reload_clr;
  logic [CHAIN_LATENCY-1:0] vld_pipe;
  logic                     step;
  logic                     coef_fire;
  logic                     sample_fire;
  logic                     reload;

  function automatic logic [NUMBER_TAPS-1:0] tap_select(input logic [TAP_W-1:0] idx);
    tap_select = '0;
    for (int i = 0; i < NUMBER_TAPS; i++) begin
      if (idx == TAP_W'(i)) tap_select[i] = 1'b1;
    end
  endfunction

  // The chain only advances when the current result has been taken or is not valid.
  assign out_valid   = vld_pipe[CHAIN_LATENCY-1];
  assign step        = !out_valid || out_ready;
  assign busy        = (state != IDLE);
  assign coef_ready  = (state == LOAD) && !reset;
  assign coef_fire   = coef_valid && coef_ready;
  assign in_ready    = (state == RUN) && step && !reset;
  assign sample_fire = in_valid && in_ready;
  assign reload      = load_start && (state != LOAD);

  // Any fresh load clears the slices; a failed load clears them again one cycle later.
  assign chain_reset_coefficient = reset || reload_clr || reload;

  always_comb begin
    chain_ce_calculate   = 1'b0;
    chain_data_in        = '0;
    chain_coefficient    = '0;
    chain_ce_coefficient = '0;
    if (!reset) begin
      case (state)
        LOAD: begin
          chain_coefficient = coef_data;
          if (coef_fire) chain_ce_coefficient = tap_select(tap_idx);
        end
        RUN: begin
          chain_data_in      = in_data;
          chain_ce_calculate = sample_fire;
        end
        FLUSH: chain_ce_calculate = step;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tap_idx    <= '0;
      flush_cnt  <= '0;
      loaded     <= 1'b0;
      load_error <= 1'b0;
      reload_clr <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      reload_clr <= 1'b0;
      // Validity tags travel with the chain: one shift per calculate enable.
      if (chain_ce_calculate) vld_pipe <= CHAIN_LATENCY'({vld_pipe, 1'b1});
      case (state)
        IDLE: begin
          if (load_start) begin
            state   <= LOAD;
            tap_idx <= '0;
          end else if (loaded) begin
            state <= RUN;
          end
        end
        LOAD: begin
          if (coef_fire) begin
            if (coef_last && tap_idx == LAST_TAP) begin
              state  <= RUN;
              loaded <= 1'b1;
            end else if (coef_last || tap_idx == LAST_TAP) begin
              state      <= IDLE;
              loaded     <= 1'b0;
              load_error <= 1'b1;
              reload_clr <= 1'b1;
            end else begin
              tap_idx <= tap_idx + 1'b1;
            end
          end
        end
        RUN: begin
          if (load_start) begin
            state    <= LOAD;
            tap_idx  <= '0;
            loaded   <= 1'b0;
            vld_pipe <= '0;
          end else if (flush_start) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (load_start) begin
            state    <= LOAD;
            tap_idx  <= '0;
            loaded   <= 1'b0;
            vld_pipe <= '0;
          end else if (chain_ce_calculate) begin
            if (flush_cnt == LAST_FLUSH) begin
              state     <= RUN;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_chain_sequencer.sv
// Bench for mac_chain_sequencer: models the MAC slices driven by the sequencer and
// scores every emitted chain result against a golden FIR of the intended stimulus.
module tb_mac_chain_sequencer;

  localparam int NT = 8;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int CL = 3;
  localparam int FL = NT + CL;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 load_start;
  logic                 coef_valid;
  logic                 coef_ready;
  logic signed [CW-1:0] coef_data;
  logic                 coef_last;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 flush_start;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] chain_data_in;
  logic signed [CW-1:0] chain_coefficient;
  logic [NT-1:0]        chain_ce_coefficient;
  logic                 chain_reset_coefficient;
  logic                 chain_ce_calculate;
  logic                 busy;
  logic                 load_error;

  mac_chain_sequencer #(
    .NUMBER_TAPS(NT), .DATA_WIDTH(DW), .COEFFICIENT_WIDTH(CW),
    .CHAIN_LATENCY(CL), .FLUSH_LENGTH(FL)
  ) dut (
    .clock(clock), .reset(reset), .load_start(load_start),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data), .coef_last(coef_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .flush_start(flush_start),
    .out_valid(out_valid), .out_ready(out_ready),
    .chain_data_in(chain_data_in), .chain_coefficient(chain_coefficient),
    .chain_ce_coefficient(chain_ce_coefficient), .chain_reset_coefficient(chain_reset_coefficient),
    .chain_ce_calculate(chain_ce_calculate), .busy(busy), .load_error(load_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  int     gold_coef [NT] = '{1, 2, 3, 4, 5, 6, 7, 8};
  longint hist      [NT];
  longint m_coef    [NT];
  longint m_taps    [NT];
  longint m_stage   [CL];
  longint exp_q     [$];
  bit     taken = 1'b0;
  bit     seen_valid = 1'b0;
  int     n_ce = 0, n_flush = 0, n_out = 0, n_cyc = 0, first_valid_ce = 0;

  initial begin
    for (int i = 0; i < NT; i++) begin hist[i] = 0; m_coef[i] = 0; m_taps[i] = 0; end
    for (int s = 0; s < CL; s++) m_stage[s] = 0;
  end

  // Slice model + scoreboard: consume the result at the chain output, then apply the coming edge.
  always @(negedge clock) begin
    bit     consumed;
    longint sum, g, e;
    consumed = 1'b0;
    n_cyc++;
    if (out_valid && !seen_valid) begin seen_valid = 1'b1; first_valid_ce = n_ce; end
    if (out_valid && out_ready && !taken) begin
      consumed = 1'b1;
      n_out++;
      check("out_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data", m_stage[CL-1], e);
      end
    end
    if (chain_reset_coefficient) begin
      for (int i = 0; i < NT; i++) m_coef[i] = 0;
    end else begin
      for (int i = 0; i < NT; i++) if (chain_ce_coefficient[i]) m_coef[i] = longint'(chain_coefficient);
    end
    if (chain_ce_calculate) begin
      n_ce++;
      if (!(in_valid && in_ready)) n_flush++;
      for (int i = NT - 1; i > 0; i--) begin m_taps[i] = m_taps[i-1]; hist[i] = hist[i-1]; end
      m_taps[0] = longint'(chain_data_in);
      hist[0]   = (in_valid && in_ready) ? longint'(in_data) : 0;
      sum = 0; g = 0;
      for (int i = 0; i < NT; i++) begin
        sum += m_coef[i] * m_taps[i];
        g   += longint'(gold_coef[i]) * hist[i];
      end
      for (int s = CL - 1; s > 0; s--) m_stage[s] = m_stage[s-1];
      m_stage[0] = sum;
      exp_q.push_back(g);
      taken = 1'b0;
    end else if (consumed) begin
      taken = 1'b1;
    end
    if (reset) begin exp_q.delete(); taken = 1'b0; end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic send(input logic signed [DW-1:0] x);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = x;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock); ok = in_ready;
      cyc();
    end
    check("send_accepted", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic load_coefs();
    load_start = 1'b1; cyc(); load_start = 1'b0;
    for (int i = 0; i < NT; i++) begin
      coef_valid = 1'b1; coef_data = CW'(gold_coef[i]); coef_last = (i == NT - 1);
      @(negedge clock);
      check("ld_ce_coef", chain_ce_coefficient, longint'(1) << i);
      check("ld_coef", chain_coefficient, gold_coef[i]);
      cyc();
    end
    coef_valid = 1'b0; coef_last = 1'b0;
    @(negedge clock);
    check("ld_busy", busy, 1);
    check("ld_in_ready", in_ready, 1);
    check("ld_error", load_error, 0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int  ce_base, cyc_base, out_base, fl_base;
    bit  ok;
    logic signed [DW-1:0] x;
    reset = 1'b1; load_start = 1'b0; coef_valid = 1'b0; coef_data = '0; coef_last = 1'b0;
    in_valid = 1'b0; in_data = '0; flush_start = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clock);
    check("rst_coef_ready", coef_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ce_calc", chain_ce_calculate, 0);
    check("rst_ce_coef", chain_ce_coefficient, 0);
    check("rst_reset_coef", chain_reset_coefficient, 1);
    check("rst_busy", busy, 0);
    check("rst_load_error", load_error, 0);
    cyc(); reset = 1'b0; cyc();

    // Premature coef_last on the fifth coefficient.
    load_start = 1'b1;
    @(negedge clock); check("load_clr_pulse", chain_reset_coefficient, 1);
    cyc(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      coef_valid = 1'b1; coef_data = CW'(i + 1); coef_last = (i == 4);
      @(negedge clock); check("err_ce_coef", chain_ce_coefficient, longint'(1) << i);
      cyc();
    end
    coef_valid = 1'b0; coef_last = 1'b0;
    @(negedge clock);
    check("err_flag", load_error, 1);
    check("err_idle", busy, 0);
    check("err_clr_pulse", chain_reset_coefficient, 1);
    cyc();
    @(negedge clock); check("err_clr_end", chain_reset_coefficient, 0);
    cyc(); in_valid = 1'b1; in_data = 16'sd123;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock); check("err_in_ready", in_ready, 0);
      cyc();
    end
    in_valid = 1'b0; reset = 1'b1; cyc(); cyc(); reset = 1'b0; cyc();

    // Good load, then a 20-sample impulse/step stream with a 5-cycle output stall.
    load_coefs();
    ce_base = n_ce; cyc_base = n_cyc; out_base = n_out;
    for (int k = 0; k < 20; k++) begin
      x = (k == 0) ? 16'sd1000 : (k < 10) ? 16'sd0 : 16'sd500;
      if (k == 10) begin
        out_ready = 1'b0; in_valid = 1'b1; in_data = x;
        for (int t = 0; t < 5; t++) begin
          @(negedge clock);
          check("stall_in_ready", in_ready, 0);
          check("stall_ce", chain_ce_calculate, 0);
          check("stall_out_valid", out_valid, 1);
          cyc();
        end
        out_ready = 1'b1;
      end
      send(x);
    end
    check("stream_ce", n_ce - ce_base, 20);
    check("stream_cycles", n_cyc - cyc_base, 25);
    check("first_valid", first_valid_ce - ce_base, CL);
    repeat (3) cyc();
    check("stream_outs", n_out - out_base, 18);

    // Four more samples, flush_start with the last one, garbage offered during the flush.
    out_base = n_out; fl_base = n_flush;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) flush_start = 1'b1;
      case (k)
        0: x = -16'sd300;
        1: x = 16'sd1200;
        2: x = 16'sd7;
        default: x = 16'sd32767;
      endcase
      send(x);
      flush_start = 1'b0;
    end
    in_valid = 1'b1; in_data = 16'sh7777;
    for (int t = 0; t < 5; t++) begin
      @(negedge clock);
      check("fl_in_ready", in_ready, 0);
      check("fl_data_zero", chain_data_in, 0);
      check("fl_ce", chain_ce_calculate, 1);
      cyc();
    end
    in_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clock); ok = in_ready;
      cyc();
    end
    check("flush_return", ok, 1);
    repeat (3) cyc();
    check("flush_enables", n_flush - fl_base, FL);
    check("flush_outs", n_out - out_base, 15);
    check("stuck_in_pipe", exp_q.size(), CL - 1);

    // Reset in the middle of a flush.
    flush_start = 1'b1; cyc(); flush_start = 1'b0; cyc(); cyc();
    reset = 1'b1; cyc();
    @(negedge clock);
    check("mf_out_valid", out_valid, 0);
    check("mf_busy", busy, 0);
    check("mf_in_ready", in_ready, 0);
    check("mf_ce_calc", chain_ce_calculate, 0);
    check("mf_coef_ready", coef_ready, 0);
    check("mf_ce_coef", chain_ce_coefficient, 0);
    check("mf_reset_coef", chain_reset_coefficient, 1);
    cyc(); reset = 1'b0; in_valid = 1'b1; in_data = 16'sd55;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock); check("mf_no_ready", in_ready, 0);
      cyc();
    end
    in_valid = 1'b0;
    load_coefs();
    out_base = n_out;
    for (int k = 0; k < 4; k++) send(DW'(100 * (k + 1)));
    repeat (3) cyc();
    check("reload_outs", n_out - out_base, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
